mult_lane_switch: RTL and testbench
===================================

Name: mult_lane_switch

Overview:
- Parametrised AXI-stream frame switch that spreads polynomial-multiply jobs over LANES parallel multiplier lanes.
- Each job is one p frame (N coefficients, QW bits) plus one u frame (N coefficients, UW bits). Jobs go to lanes in round-robin order.
- Result frames are collected in the same order, so z leaves in job order.
- Sits between the encoder datapath and an array of multiplier instances. Replaces the fixed two-lane switch with correct vld&rdy handshakes, lane occupancy tracking and a registered output stage.

Parameters:
- LANES, 2, number of multiplier lanes; any value >= 2.
- N, 16, coefficients per frame.
- QW, 64, width of p and z coefficients.
- UW, 1, width of u coefficients.

Ports:
- clk  in  1  system clock.
- s_rst  in  1  synchronous reset, active-high.
- p_data  in  QW  upstream p coefficient.
- p_vld  in  1  p beat valid.
- p_last  in  1  last p beat of frame.
- p_rdy  out  1  p beat accepted when p_vld & p_rdy.
- u_data  in  UW  upstream u coefficient.
- u_vld  in  1  u beat valid.
- u_last  in  1  last u beat of frame.
- u_rdy  out  1  u ready.
- lp_data  out  LANES*QW  p data to lanes, lane i at [i*QW +: QW].
- lp_vld  out  LANES  per-lane p valid.
- lp_last  out  LANES  per-lane p last.
- lp_rdy  in  LANES  per-lane p ready.
- lu_data  out  LANES*UW  u data to lanes.
- lu_vld  out  LANES  per-lane u valid.
- lu_last  out  LANES  per-lane u last.
- lu_rdy  in  LANES  per-lane u ready.
- lz_data  in  LANES*QW  lane results.
- lz_vld  in  LANES  per-lane z valid.
- lz_last  in  LANES  per-lane z last.
- lz_rdy  out  LANES  per-lane z ready.
- z_data  out  QW  result coefficient.
- z_vld  out  1  result valid.
- z_last  out  1  last result beat.
- z_rdy  in  1  downstream ready.
- busy  out  LANES  lane occupancy flags, occ[i].
- err  out  1  sticky frame-length error.

Behaviour:
- Single clock domain; s_rst is synchronous, active-high.
- Reset values:
  - Pointers p_sel, u_sel, z_sel = 0.
  - occ, u_done, p_in_frame = 0.
  - z_vld, z_last, z_data, err = 0.
  - p_rdy, u_rdy, lp_vld, lu_vld, lz_rdy forced 0 while s_rst is high.
- Reset mid-frame discards all state. Lanes share s_rst.
- p dispatch:
  - lp_data/lu_data broadcast to all lanes; only lp_vld[p_sel] = p_vld. The same applies to lp_last.
  - p_rdy = lp_rdy[p_sel] & (p_in_frame | !occ[p_sel]), combinational.
  - First accepted beat sets occ[p_sel] and p_in_frame.
  - Accepted beat with p_last clears p_in_frame and advances p_sel (LANES-1 wraps to 0).
- u dispatch:
  - Same muxing on u_sel.
  - u_rdy = lu_rdy[u_sel] & occ[u_sel] & !u_done[u_sel], so u of a job never precedes its p.
  - Accepted u_last sets u_done[u_sel] and advances u_sel with wrap.
- z collect:
  - lz_rdy[z_sel] = output stage not full; other lz_rdy = 0.
  - Output stage is a 2-entry skid buffer. Latency is 1 cycle lane-beat to z_vld, and throughput is 1 beat/cycle.
  - Output data is held stable while z_vld & !z_rdy.
  - An accepted lane beat with lz_last clears occ[z_sel] and u_done[z_sel], and advances z_sel with wrap.
- Simultaneous events:
  - A clear of occ[i] in the same cycle that p_sel==i sees no new start, because p_rdy uses the registered occ. The new frame starts on the next cycle.
  - p and u handshakes in the same cycle are independent.
- All lanes occupied: p stalls (p_rdy=0) until the oldest lane drains.
- Lane outputs from a lane != z_sel are not accepted, even if lz_vld is high.

Optional Feature:
- Macro: MULT_LANE_SWITCH_LEN_CHECK_EN.
- Defined: beat counters of width $clog2(N+1) run on the p, u and z streams.
  - err is set one cycle after a handshake where last is high and the count != N-1.
  - err is also set when a beat is accepted at count N-1 without last.
  - err is sticky until s_rst. Data and handshakes are never altered.
- Undefined: no counters are built and err is tied to 0.

Test Plan:
- LANES=2, N=16: two back-to-back jobs with p=1..16 and u=all-ones; lane i echoes p → z carries frame 0 then frame 1 in order; busy goes 01→11→10→00.
- LANES=3: four jobs sent, lanes return results in reverse completion order → z order stays job 0,1,2,3; the 4th p frame stalls until lane 0 drains.
- z_rdy toggled 1010… during a 16-beat output → no beat lost or duplicated; z_data stable while stalled.
- u frame presented before its p frame → u_rdy=0 until the first p beat is accepted, then 16 u beats pass.
- s_rst asserted at beat 7 of a p frame → all outputs reach their reset values on the next cycle; a new job afterwards goes to lane 0.
- With MULT_LANE_SWITCH_LEN_CHECK_EN: p_last on beat 10 → err=1 on the following cycle and stays high; without the macro → err=0.

Source files
------------

// File: rtl/mult_lane_switch.sv
// Round-robin AXI-stream job switch feeding LANES multiplier lanes and collecting results in job order.
// Optional frame-length checker enabled by defining MULT_LANE_SWITCH_LEN_CHECK_EN.
module mult_lane_switch #(
    parameter int LANES = 2,
    parameter int N     = 16,
    parameter int QW    = 64,
    parameter int UW    = 1
) (
    input  logic                clk,
    input  logic                s_rst,
    input  logic [QW-1:0]       p_data,
    input  logic                p_vld,
    input  logic                p_last,
    output logic                p_rdy,
    input  logic [UW-1:0]       u_data,
    input  logic                u_vld,
    input  logic                u_last,
    output logic                u_rdy,
    output logic [LANES*QW-1:0] lp_data,
    output logic [LANES-1:0]    lp_vld,
    output logic [LANES-1:0]    lp_last,
    input  logic [LANES-1:0]    lp_rdy,
    output logic [LANES*UW-1:0] lu_data,
    output logic [LANES-1:0]    lu_vld,
    output logic [LANES-1:0]    lu_last,
    input  logic [LANES-1:0]    lu_rdy,
    input  logic [LANES*QW-1:0] lz_data,
    input  logic [LANES-1:0]    lz_vld,
    input  logic [LANES-1:0]    lz_last,
    output logic [LANES-1:0]    lz_rdy,
    output logic [QW-1:0]       z_data,
    output logic                z_vld,
    output logic                z_last,
    input  logic                z_rdy,
    output logic [LANES-1:0]    busy,
    output logic                err
);
    localparam int PW = $clog2(LANES);

    logic [PW-1:0]    p_sel_q, p_sel_d, u_sel_q, u_sel_d, z_sel_q, z_sel_d;
    logic [LANES-1:0] occ_q, occ_d, u_done_q, u_done_d;
    logic             p_in_frame_q, p_in_frame_d;
    logic [QW-1:0]    z_data_q, z_data_d, sk_data_q, sk_data_d;
    logic             z_vld_q, z_vld_d, z_last_q, z_last_d, sk_vld_q, sk_vld_d, sk_last_q, sk_last_d;

    logic             p_ok_s, u_ok_s, p_fire_s, u_fire_s;
    logic             in_vld_s, in_last_s, in_fire_s, out_fire_s;
    logic [QW-1:0]    in_data_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == PW'(LANES-1)) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    assign lp_data = {LANES{p_data}};
    assign lu_data = {LANES{u_data}};
    assign busy    = occ_q;
    assign z_data  = z_data_q;
    assign z_vld   = z_vld_q;
    assign z_last  = z_last_q;

    // Upstream/downstream handshake qualification from registered occupancy
    always_comb begin
        p_ok_s     = p_in_frame_q | ~occ_q[p_sel_q];
        u_ok_s     = occ_q[u_sel_q] & ~u_done_q[u_sel_q];
        p_rdy      = lp_rdy[p_sel_q] & p_ok_s & ~s_rst;
        u_rdy      = lu_rdy[u_sel_q] & u_ok_s & ~s_rst;
        p_fire_s   = p_vld & p_rdy;
        u_fire_s   = u_vld & u_rdy;
        in_vld_s   = lz_vld[z_sel_q];
        in_last_s  = lz_last[z_sel_q];
        in_data_s  = lz_data[int'(z_sel_q)*QW +: QW];
        in_fire_s  = in_vld_s & ~sk_vld_q & ~s_rst;
        out_fire_s = z_vld_q & z_rdy;
    end

    // Per-lane valid/ready steering; lane valids are gated so a lane never sees a beat the switch rejects
    always_comb begin
        lp_vld  = {LANES{1'b0}};
        lp_last = {LANES{1'b0}};
        lu_vld  = {LANES{1'b0}};
        lu_last = {LANES{1'b0}};
        lz_rdy  = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (PW'(i) == p_sel_q) begin
                lp_vld[i]  = p_vld & p_ok_s & ~s_rst;
                lp_last[i] = p_last;
            end else begin
                lp_vld[i]  = 1'b0;
                lp_last[i] = 1'b0;
            end
            if (PW'(i) == u_sel_q) begin
                lu_vld[i]  = u_vld & u_ok_s & ~s_rst;
                lu_last[i] = u_last;
            end else begin
                lu_vld[i]  = 1'b0;
                lu_last[i] = 1'b0;
            end
            if (PW'(i) == z_sel_q) begin
                lz_rdy[i] = ~sk_vld_q & ~s_rst;
            end else begin
                lz_rdy[i] = 1'b0;
            end
        end
    end

    // Pointer, occupancy and skid-buffer next state; a z clear wins over any set on the same lane
    always_comb begin
        p_sel_d      = p_sel_q;
        u_sel_d      = u_sel_q;
        z_sel_d      = z_sel_q;
        occ_d        = occ_q;
        u_done_d     = u_done_q;
        p_in_frame_d = p_in_frame_q;
        z_data_d     = z_data_q;
        z_vld_d      = z_vld_q;
        z_last_d     = z_last_q;
        sk_data_d    = sk_data_q;
        sk_vld_d     = sk_vld_q;
        sk_last_d    = sk_last_q;
        if (p_fire_s) begin
            occ_d[p_sel_q] = 1'b1;
            if (p_last) begin
                p_in_frame_d = 1'b0;
                p_sel_d      = next_ptr(p_sel_q);
            end else begin
                p_in_frame_d = 1'b1;
            end
        end else begin
            p_in_frame_d = p_in_frame_q;
        end
        if (u_fire_s & u_last) begin
            u_done_d[u_sel_q] = 1'b1;
            u_sel_d           = next_ptr(u_sel_q);
        end else begin
            u_sel_d = u_sel_q;
        end
        if (in_fire_s & in_last_s) begin
            occ_d[z_sel_q]    = 1'b0;
            u_done_d[z_sel_q] = 1'b0;
            z_sel_d           = next_ptr(z_sel_q);
        end else begin
            z_sel_d = z_sel_q;
        end
        // Main register refills from skid first; skid only fills while the main register is stalled
        if (~z_vld_q | out_fire_s) begin
            if (sk_vld_q) begin
                z_data_d = sk_data_q;
                z_last_d = sk_last_q;
                z_vld_d  = 1'b1;
                sk_vld_d = 1'b0;
            end else if (in_fire_s) begin
                z_data_d = in_data_s;
                z_last_d = in_last_s;
                z_vld_d  = 1'b1;
            end else begin
                z_vld_d  = 1'b0;
                z_last_d = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                sk_data_d = in_data_s;
                sk_last_d = in_last_s;
                sk_vld_d  = 1'b1;
            end else begin
                sk_vld_d = sk_vld_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (s_rst) begin
            p_sel_q      <= {PW{1'b0}};
            u_sel_q      <= {PW{1'b0}};
            z_sel_q      <= {PW{1'b0}};
            occ_q        <= {LANES{1'b0}};
            u_done_q     <= {LANES{1'b0}};
            p_in_frame_q <= 1'b0;
            z_data_q     <= {QW{1'b0}};
            z_vld_q      <= 1'b0;
            z_last_q     <= 1'b0;
            sk_data_q    <= {QW{1'b0}};
            sk_vld_q     <= 1'b0;
            sk_last_q    <= 1'b0;
        end else begin
            p_sel_q      <= p_sel_d;
            u_sel_q      <= u_sel_d;
            z_sel_q      <= z_sel_d;
            occ_q        <= occ_d;
            u_done_q     <= u_done_d;
            p_in_frame_q <= p_in_frame_d;
            z_data_q     <= z_data_d;
            z_vld_q      <= z_vld_d;
            z_last_q     <= z_last_d;
            sk_data_q    <= sk_data_d;
            sk_vld_q     <= sk_vld_d;
            sk_last_q    <= sk_last_d;
        end
    end

`ifdef MULT_LANE_SWITCH_LEN_CHECK_EN
    localparam int CW = $clog2(N+1);

    logic [CW-1:0] p_cnt_q, p_cnt_d, u_cnt_q, u_cnt_d, z_cnt_q, z_cnt_d;
    logic          err_q, err_d;

    function automatic logic len_bad(input logic [CW-1:0] cnt, input logic last);
        if (last) begin
            return cnt != CW'(N-1);
        end else begin
            return cnt == CW'(N-1);
        end
    endfunction

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt, input logic last);
        if (last) begin
            return {CW{1'b0}};
        end else if (cnt == CW'(N)) begin
            return cnt;
        end else begin
            return cnt + CW'(1);
        end
    endfunction

    // Beat counters and sticky length error
    always_comb begin
        p_cnt_d = p_fire_s ? cnt_next(p_cnt_q, p_last) : p_cnt_q;
        u_cnt_d = u_fire_s ? cnt_next(u_cnt_q, u_last) : u_cnt_q;
        z_cnt_d = out_fire_s ? cnt_next(z_cnt_q, z_last_q) : z_cnt_q;
        err_d   = err_q
                | (p_fire_s & len_bad(p_cnt_q, p_last))
                | (u_fire_s & len_bad(u_cnt_q, u_last))
                | (out_fire_s & len_bad(z_cnt_q, z_last_q));
    end

    // Length checker registers
    always_ff @(posedge clk) begin
        if (s_rst) begin
            p_cnt_q <= {CW{1'b0}};
            u_cnt_q <= {CW{1'b0}};
            z_cnt_q <= {CW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            p_cnt_q <= p_cnt_d;
            u_cnt_q <= u_cnt_d;
            z_cnt_q <= z_cnt_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mult_lane_switch.sv
// Self-checking bench for mult_lane_switch: behavioural lanes echo p, expected z is the p stream in job order.
module tb_mult_lane_switch;
    localparam int LANES = 3;
    localparam int N     = 16;
    localparam int QW    = 32;
    localparam int UW    = 1;

    typedef struct packed {
        logic          l;
        logic [QW-1:0] d;
    } beat_t;

    logic                clk, s_rst;
    logic [QW-1:0]       p_data;
    logic                p_vld, p_last, p_rdy;
    logic [UW-1:0]       u_data;
    logic                u_vld, u_last, u_rdy;
    logic [LANES*QW-1:0] lp_data;
    logic [LANES-1:0]    lp_vld, lp_last, lp_rdy;
    logic [LANES*UW-1:0] lu_data;
    logic [LANES-1:0]    lu_vld, lu_last, lu_rdy;
    logic [LANES*QW-1:0] lz_data;
    logic [LANES-1:0]    lz_vld, lz_last, lz_rdy;
    logic [QW-1:0]       z_data;
    logic                z_vld, z_last, z_rdy;
    logic [LANES-1:0]    busy;
    logic                err;

    mult_lane_switch #(.LANES(LANES), .N(N), .QW(QW), .UW(UW)) dut (
        .clk(clk), .s_rst(s_rst),
        .p_data(p_data), .p_vld(p_vld), .p_last(p_last), .p_rdy(p_rdy),
        .u_data(u_data), .u_vld(u_vld), .u_last(u_last), .u_rdy(u_rdy),
        .lp_data(lp_data), .lp_vld(lp_vld), .lp_last(lp_last), .lp_rdy(lp_rdy),
        .lu_data(lu_data), .lu_vld(lu_vld), .lu_last(lu_last), .lu_rdy(lu_rdy),
        .lz_data(lz_data), .lz_vld(lz_vld), .lz_last(lz_last), .lz_rdy(lz_rdy),
        .z_data(z_data), .z_vld(z_vld), .z_last(z_last), .z_rdy(z_rdy),
        .busy(busy), .err(err)
    );

    beat_t            p_q[$], u_q[$], exp_z[$], z_cap[$];
    int               lane_log[$];
    logic [LANES-1:0] busy_log[$];
    logic [LANES-1:0] release_r;
    int               checks, errors, jobs, zmode, stall_viol, p_fire_cnt;
    bit               rand_gap, exp_err;
    logic [QW-1:0]    lbuf [LANES][N];
    int               lpcnt [LANES], lucnt [LANES], lzidx [LANES];
    bit               lpdone [LANES], ludone [LANES];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // p source: one beat per cycle from p_q, optionally with random gaps
    initial begin : p_src
        bit fire;
        fire = 1'b0; p_vld = 1'b0; p_data = '0; p_last = 1'b0; p_fire_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (fire && p_q.size() > 0) p_q.delete(0);
            if (p_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                p_vld = 1'b1; p_data = p_q[0].d; p_last = p_q[0].l;
            end else begin
                p_vld = 1'b0;
            end
            @(negedge clk);
            fire = p_vld & p_rdy;
            if (fire) p_fire_cnt++;
        end
    end

    // u source
    initial begin : u_src
        bit fire;
        fire = 1'b0; u_vld = 1'b0; u_data = '0; u_last = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fire && u_q.size() > 0) u_q.delete(0);
            if (u_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                u_vld = 1'b1; u_data = u_q[0].d[0]; u_last = u_q[0].l;
            end else begin
                u_vld = 1'b0;
            end
            @(negedge clk);
            fire = u_vld & u_rdy;
        end
    end

    // z sink: capture accepted beats and count data changes while stalled
    initial begin : z_snk
        logic [QW-1:0] held;
        bit hold;
        beat_t b;
        hold = 1'b0; held = '0; z_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (s_rst) hold = 1'b0;
            case (zmode)
                0:       z_rdy = 1'b1;
                1:       z_rdy = ~z_rdy;
                default: z_rdy = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (hold && (!z_vld || z_data !== held)) stall_viol++;
            if (z_vld && z_rdy) begin
                b.l = z_last; b.d = z_data; z_cap.push_back(b); hold = 1'b0;
            end else if (z_vld) begin
                hold = 1'b1; held = z_data;
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Behavioural lanes: buffer one p frame, wait for its u frame, echo p as z when released
    initial begin : lanes
        bit pf [LANES], uf [LANES], zf [LANES], zl [LANES];
        logic [QW-1:0] pd;
        bit pl, ul;
        lp_rdy = '0; lu_rdy = '0; lz_vld = '0; lz_data = '0; lz_last = '0; pd = '0; pl = 0; ul = 0;
        for (int i = 0; i < LANES; i++) begin
            pf[i] = 0; uf[i] = 0; zf[i] = 0; zl[i] = 0;
            lpcnt[i] = 0; lucnt[i] = 0; lzidx[i] = 0; lpdone[i] = 0; ludone[i] = 0;
        end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < LANES; i++) begin
                if (s_rst) begin
                    lpcnt[i] = 0; lucnt[i] = 0; lzidx[i] = 0; lpdone[i] = 0; ludone[i] = 0;
                end else begin
                    if (pf[i]) begin
                        if (lpcnt[i] == 0) lane_log.push_back(i);
                        if (lpcnt[i] < N) begin lbuf[i][lpcnt[i]] = pd; lpcnt[i]++; end
                        if (pl) lpdone[i] = 1;
                    end
                    if (uf[i]) begin
                        lucnt[i]++;
                        if (ul) ludone[i] = 1;
                    end
                    if (zf[i]) begin
                        if (zl[i]) begin
                            lpcnt[i] = 0; lucnt[i] = 0; lzidx[i] = 0; lpdone[i] = 0; ludone[i] = 0;
                        end else begin
                            lzidx[i]++;
                        end
                    end
                end
                lp_rdy[i] = !lpdone[i] && (!rand_gap || $urandom_range(0, 1) == 1);
                lu_rdy[i] = !ludone[i] && (!rand_gap || $urandom_range(0, 1) == 1);
                lz_vld[i] = lpdone[i] && ludone[i] && release_r[i];
                lz_data[i*QW +: QW] = lz_vld[i] ? lbuf[i][lzidx[i]] : '0;
                lz_last[i] = lz_vld[i] && (lzidx[i] == lpcnt[i] - 1);
            end
            @(negedge clk);
            pd = p_data; pl = p_last; ul = u_last;
            for (int i = 0; i < LANES; i++) begin
                pf[i] = lp_vld[i] & lp_rdy[i];
                uf[i] = lu_vld[i] & lu_rdy[i];
                zf[i] = lz_vld[i] & lz_rdy[i];
                zl[i] = lz_last[i];
            end
        end
    end

    // busy change log
    initial begin : busy_mon
        logic [LANES-1:0] prev;
        prev = '0;
        forever begin
            @(posedge clk); #2;
            if (busy !== prev) begin busy_log.push_back(busy); prev = busy; end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #3; end
    endtask

    task automatic push_p(input int mode, input int plen);
        beat_t b;
        for (int k = 0; k < plen; k++) begin
            b.l = (k == plen - 1);
            b.d = (mode == 0) ? QW'(k + 1) : QW'($urandom);
            p_q.push_back(b); exp_z.push_back(b);
        end
        jobs++;
    endtask

    task automatic push_u(input int mode);
        beat_t b;
        for (int k = 0; k < N; k++) begin
            b.l = (k == N - 1);
            b.d = (mode == 0) ? QW'(1) : QW'($urandom_range(0, 1));
            u_q.push_back(b);
        end
    endtask

    task automatic send_job(input int mode, input int plen);
        push_p(mode, plen);
        push_u(mode);
    endtask

    task automatic wait_idle(output bit ok);
        int c;
        c = 0; ok = 1'b1;
        while (!(p_q.size() == 0 && u_q.size() == 0 && z_cap.size() >= exp_z.size())) begin
            tick(1); c++;
            if (c > 3000) begin ok = 1'b0; break; end
        end
        tick(3);
    endtask

    function automatic int z_diff();
        int n;
        n = 0;
        for (int k = 0; k < exp_z.size(); k++)
            if (k >= z_cap.size() || z_cap[k] !== exp_z[k]) n++;
        if (z_cap.size() > exp_z.size()) n += z_cap.size() - exp_z.size();
        return n;
    endfunction

    function automatic int lane_diff();
        int n;
        n = (lane_log.size() == jobs) ? 0 : 1;
        for (int k = 0; k < lane_log.size(); k++)
            if (lane_log[k] != k % LANES) n++;
        return n;
    endfunction

    function automatic bit all_full();
        bit f;
        f = 1'b1;
        for (int i = 0; i < LANES; i++) f &= lpdone[i] && ludone[i];
        return f;
    endfunction

    task automatic do_reset();
        s_rst = 1'b1;
        p_q.delete(); u_q.delete();
        tick(2);
        s_rst = 1'b0;
        exp_z.delete(); z_cap.delete(); lane_log.delete(); busy_log.delete();
        jobs = 0; release_r = '1; zmode = 0; rand_gap = 1'b0; stall_viol = 0;
        tick(1);
    endtask

    task automatic test_reset();
        send_job(1, N);
        s_rst = 1'b1;
        tick(3);
        checks++; if (p_rdy !== 1'b0) begin errors++; $display("FAIL reset_p_rdy got %b want 0", p_rdy); end
        checks++; if (u_rdy !== 1'b0) begin errors++; $display("FAIL reset_u_rdy got %b want 0", u_rdy); end
        checks++; if (lp_vld !== '0 || lu_vld !== '0) begin errors++; $display("FAIL reset_lane_vld got %b/%b want 0", lp_vld, lu_vld); end
        checks++; if (lz_rdy !== '0) begin errors++; $display("FAIL reset_lz_rdy got %b want 0", lz_rdy); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (z_vld !== 1'b0 || z_last !== 1'b0 || z_data !== '0) begin errors++; $display("FAIL reset_z got vld=%b last=%b data=%h want 0", z_vld, z_last, z_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        do_reset();
    endtask

    task automatic test_two_jobs();
        bit ok;
        int nb;
        logic [LANES-1:0] exp_b [4];
        exp_b[0] = 3'b001; exp_b[1] = 3'b011; exp_b[2] = 3'b010; exp_b[3] = 3'b000;
        do_reset();
        send_job(0, N); send_job(0, N);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_jobs_timeout got z=%0d want %0d", z_cap.size(), exp_z.size()); end
        checks++; if (z_diff() != 0) begin errors++; $display("FAIL two_jobs_z got %0d bad beats want 0", z_diff()); end
        checks++; if (lane_diff() != 0) begin errors++; $display("FAIL two_jobs_lanes got %0d bad want 0", lane_diff()); end
        nb = (busy_log.size() == 4) ? 0 : 1;
        for (int k = 0; k < busy_log.size() && k < 4; k++) if (busy_log[k] !== exp_b[k]) nb++;
        checks++; if (nb != 0) begin errors++; $display("FAIL two_jobs_busy got %0d changes/%0d bad want 01,11,10,00", busy_log.size(), nb); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL two_jobs_err got %b want 0", err); end
    endtask

    task automatic test_reorder();
        bit ok;
        int c;
        do_reset();
        release_r = '0;
        for (int j = 0; j < 4; j++) send_job(1, N);
        c = 0;
        while (!all_full() && c < 500) begin tick(1); c++; end
        tick(4);
        checks++; if (!all_full()) begin errors++; $display("FAIL reorder_fill got not full want all lanes loaded"); end
        checks++; if (busy !== 3'b111) begin errors++; $display("FAIL reorder_busy got %b want 111", busy); end
        checks++; if (p_vld !== 1'b1 || p_rdy !== 1'b0) begin errors++; $display("FAIL reorder_stall got vld=%b rdy=%b want 1/0", p_vld, p_rdy); end
        release_r = 3'b100;
        tick(6);
        checks++; if (z_cap.size() != 0 || lz_rdy[2] !== 1'b0) begin errors++; $display("FAIL reorder_lane2_early got z=%0d lz_rdy=%b want 0/0", z_cap.size(), lz_rdy); end
        release_r = 3'b110;
        tick(6);
        checks++; if (z_vld !== 1'b0) begin errors++; $display("FAIL reorder_lane1_early got z_vld=%b want 0", z_vld); end
        release_r = 3'b111;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL reorder_timeout got z=%0d want %0d", z_cap.size(), exp_z.size()); end
        checks++; if (z_diff() != 0) begin errors++; $display("FAIL reorder_z got %0d bad beats want 0", z_diff()); end
        checks++; if (lane_diff() != 0) begin errors++; $display("FAIL reorder_lanes got %0d bad want 0", lane_diff()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        zmode = 1;
        send_job(1, N);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got z=%0d want %0d", z_cap.size(), exp_z.size()); end
        checks++; if (z_diff() != 0) begin errors++; $display("FAIL bp_z got %0d bad beats want 0", z_diff()); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_viol); end
    endtask

    task automatic test_random();
        bit ok;
        do_reset();
        zmode = 2; rand_gap = 1'b1;
        for (int j = 0; j < 7; j++) send_job(1, N);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_timeout got z=%0d want %0d", z_cap.size(), exp_z.size()); end
        checks++; if (z_diff() != 0) begin errors++; $display("FAIL rand_z got %0d bad beats want 0", z_diff()); end
        checks++; if (lane_diff() != 0) begin errors++; $display("FAIL rand_lanes got %0d bad want 0", lane_diff()); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stable got %0d changes want 0", stall_viol); end
    endtask

    task automatic test_u_before_p();
        bit ok;
        do_reset();
        push_u(1);
        tick(6);
        checks++; if (u_vld !== 1'b1 || u_rdy !== 1'b0) begin errors++; $display("FAIL ufirst_block got vld=%b rdy=%b want 1/0", u_vld, u_rdy); end
        checks++; if (lucnt[0] != 0) begin errors++; $display("FAIL ufirst_lane_u got %0d want 0", lucnt[0]); end
        push_p(1, N);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ufirst_timeout got u_left=%0d want 0", u_q.size()); end
        checks++; if (z_diff() != 0) begin errors++; $display("FAIL ufirst_z got %0d bad beats want 0", z_diff()); end
    endtask

    task automatic test_srst_mid();
        bit ok;
        int base, c;
        do_reset();
        base = p_fire_cnt;
        send_job(0, N);
        c = 0;
        while (p_fire_cnt - base < 7 && c < 200) begin tick(1); c++; end
        checks++; if (p_fire_cnt - base < 7) begin errors++; $display("FAIL srst_reach got %0d beats want 7", p_fire_cnt - base); end
        s_rst = 1'b1;
        p_q.delete(); u_q.delete();
        #1;
        checks++; if (p_rdy !== 1'b0 || u_rdy !== 1'b0 || lp_vld !== '0 || lz_rdy !== '0) begin errors++; $display("FAIL srst_comb got p_rdy=%b u_rdy=%b lp_vld=%b lz_rdy=%b want 0", p_rdy, u_rdy, lp_vld, lz_rdy); end
        tick(1);
        checks++; if (busy !== '0 || z_vld !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL srst_regs got busy=%b z_vld=%b err=%b want 0", busy, z_vld, err); end
        s_rst = 1'b0;
        exp_z.delete(); z_cap.delete(); lane_log.delete(); jobs = 0;
        tick(1);
        send_job(1, N);
        wait_idle(ok);
        checks++; if (!ok || lane_log.size() != 1 || lane_log[0] != 0) begin errors++; $display("FAIL srst_lane got %0d jobs first lane %0d want 1/0", lane_log.size(), lane_log.size() > 0 ? lane_log[0] : -1); end
        checks++; if (z_diff() != 0) begin errors++; $display("FAIL srst_z got %0d bad beats want 0", z_diff()); end
    endtask

    task automatic test_len_check();
        bit ok;
        int c;
        do_reset();
        send_job(1, N);
        wait_idle(ok);
        checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL len_good got err=%b ok=%b want 0/1", err, ok); end
        send_job(1, 10);
        c = 0;
        while (p_q.size() != 0 && c < 200) begin tick(1); c++; end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL len_short got %b want %b", err, exp_err); end
        wait_idle(ok);
        tick(20);
        checks++; if (err !== exp_err) begin errors++; $display("FAIL len_sticky got %b want %b", err, exp_err); end
        checks++; if (z_diff() != 0) begin errors++; $display("FAIL len_z got %0d bad beats want 0", z_diff()); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL len_clear got %b want 0", err); end
    endtask

    initial begin
        checks = 0; errors = 0; jobs = 0; zmode = 0; rand_gap = 1'b0; stall_viol = 0;
        release_r = '1; s_rst = 1'b1;
`ifdef MULT_LANE_SWITCH_LEN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        test_reset();
        test_two_jobs();
        test_reorder();
        test_backpressure();
        test_random();
        test_u_before_p();
        test_srst_mid();
        test_len_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
